// File: rtl/ads1292_float_arbiter.sv
// Round-robin arbiter sharing one float conversion/arithmetic unit (stb/ack
// handshake) between N_REQ requesters, with one transaction in flight at a time.
module ads1292_float_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTN,
  input  logic [N_REQ*DATA_W-1:0] i_REQ_A,
  input  logic [N_REQ-1:0]        i_REQ_STB,
  output logic [N_REQ-1:0]        o_REQ_ACK,
  output logic [DATA_W-1:0]       o_RSP_Z,
  output logic [N_REQ-1:0]        o_RSP_STB,
  input  logic [N_REQ-1:0]        i_RSP_ACK,
  output logic [DATA_W-1:0]       o_UNIT_A,
  output logic                    o_UNIT_A_STB,
  input  logic                    i_UNIT_A_ACK,
  input  logic [DATA_W-1:0]       i_UNIT_Z,
  input  logic                    i_UNIT_Z_STB,
  output logic                    o_UNIT_Z_ACK,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_GRANT,
  output logic                    o_BUSY,
  output logic                    o_TIMEOUT
);

  localparam int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_Z, ST_RETURN} state_t;

  state_t               state_reg, state_next;
  logic [GRANT_W-1:0]   last_reg, last_next;
  logic [GRANT_W-1:0]   grant_reg, grant_next;
  logic [DATA_W-1:0]    op_reg, op_next;
  logic [DATA_W-1:0]    rsp_z_reg, rsp_z_next;
  logic [N_REQ-1:0]     rsp_stb_reg, rsp_stb_next;
  logic [N_REQ-1:0]     req_ack_reg, req_ack_next;
  logic                 z_ack_reg, z_ack_next;
  logic                 timeout_reg, timeout_next;
  logic [15:0]          cnt_reg, cnt_next;

  logic [DATA_W-1:0]    req_a_arr [N_REQ];
  logic                 hi_found, lo_found, found;
  logic [GRANT_W-1:0]   hi_pick, lo_pick, pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = i_REQ_A[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Two-pass priority search: indices above the last grant win over those at or
  // below it; the descending loop leaves the lowest index of each pass selected.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_REQ_STB[GRANT_W'(j)]) begin
        if (GRANT_W'(j) > last_reg) begin
          hi_found = 1'b1;
          hi_pick  = GRANT_W'(j);
        end else begin
          lo_found = 1'b1;
          lo_pick  = GRANT_W'(j);
        end
      end
    end
    found = hi_found | lo_found;
    pick  = hi_found ? hi_pick : lo_pick;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_reg   <= ST_IDLE;
      last_reg    <= GRANT_W'(N_REQ - 1);
      grant_reg   <= '0;
      op_reg      <= '0;
      rsp_z_reg   <= '0;
      rsp_stb_reg <= '0;
      req_ack_reg <= '0;
      z_ack_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      grant_reg   <= grant_next;
      op_reg      <= op_next;
      rsp_z_reg   <= rsp_z_next;
      rsp_stb_reg <= rsp_stb_next;
      req_ack_reg <= req_ack_next;
      z_ack_reg   <= z_ack_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    grant_next   = grant_reg;
    op_next      = op_reg;
    rsp_z_next   = rsp_z_reg;
    rsp_stb_next = rsp_stb_reg;
    req_ack_next = '0;
    z_ack_next   = 1'b0;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          grant_next   = pick;
          op_next      = req_a_arr[pick];
          req_ack_next = N_REQ'(1) << pick;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_UNIT_A_ACK) begin
          cnt_next   = '0;
          state_next = ST_WAIT_Z;
        end
      end
      ST_WAIT_Z: begin
        cnt_next = cnt_reg + 16'd1;
        // A result arriving on the last allowed cycle still beats the abort.
        if (i_UNIT_Z_STB) begin
          rsp_z_next   = i_UNIT_Z;
          z_ack_next   = 1'b1;
          rsp_stb_next = N_REQ'(1) << grant_reg;
          state_next   = ST_RETURN;
        end else if (cnt_reg == TO_LAST) begin
          timeout_next = 1'b1;
          z_ack_next   = 1'b1;
          last_next    = grant_reg;
          state_next   = ST_IDLE;
        end
      end
      ST_RETURN: begin
        if (i_RSP_ACK[grant_reg] && rsp_stb_reg[grant_reg]) begin
          rsp_stb_next = '0;
          last_next    = grant_reg;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_REQ_ACK    = req_ack_reg;
  assign o_RSP_Z      = rsp_z_reg;
  assign o_RSP_STB    = rsp_stb_reg;
  assign o_UNIT_A     = op_reg;
  assign o_UNIT_A_STB = (state_reg == ST_ISSUE) && i_UNIT_A_ACK;
  assign o_UNIT_Z_ACK = z_ack_reg;
  assign o_GRANT      = grant_reg;
  assign o_BUSY       = (state_reg != ST_IDLE);
  assign o_TIMEOUT    = timeout_reg;

endmodule

// File: tb/tb_ads1292_float_arbiter.sv
// Directed bench for ads1292_float_arbiter: single request, round-robin order,
// unit back-pressure, timeout, Z_STB/timeout collision and reset mid-transaction.
module tb_ads1292_float_arbiter;

  logic        clk;
  logic        rstn;
  logic [95:0] req_a;
  logic [2:0]  req_stb, req_ack, rsp_stb, rsp_ack;
  logic [31:0] rsp_z, unit_a, unit_z;
  logic        unit_a_stb, unit_a_ack, unit_z_stb, unit_z_ack;
  logic [1:0]  grant;
  logic        busy, tmo;

  int total = 0;
  int bad   = 0;

  ads1292_float_arbiter #(.N_REQ(3), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .i_CLK(clk), .i_RSTN(rstn),
    .i_REQ_A(req_a), .i_REQ_STB(req_stb), .o_REQ_ACK(req_ack),
    .o_RSP_Z(rsp_z), .o_RSP_STB(rsp_stb), .i_RSP_ACK(rsp_ack),
    .o_UNIT_A(unit_a), .o_UNIT_A_STB(unit_a_stb), .i_UNIT_A_ACK(unit_a_ack),
    .i_UNIT_Z(unit_z), .i_UNIT_Z_STB(unit_z_stb), .o_UNIT_Z_ACK(unit_z_ack),
    .o_GRANT(grant), .o_BUSY(busy), .o_TIMEOUT(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    req_a = {a2, a1, a0};
  endtask

  // Steps until a request ack appears, bounded.
  task automatic wait_ack();
    int n;
    n = 0;
    while (req_ack == 3'b000 && n < 20) begin
      step();
      n++;
    end
    check("ack_wait_bound", {31'd0, n < 20}, 32'd1);
  endtask

  // From ST_ISSUE with the unit ready: issue, zero-latency result, return, consume.
  task automatic finish_txn(input logic [2:0] oh, input logic [31:0] z_drive,
                            input logic [31:0] z_exp);
    step();
    check("issued_stb_low", {31'd0, unit_a_stb}, 32'd0);
    unit_z_stb = 1'b1;
    unit_z     = z_drive;
    step();
    unit_z_stb = 1'b0;
    check("rsp_stb", {29'd0, rsp_stb}, {29'd0, oh});
    check("rsp_z", rsp_z, z_exp);
    check("z_ack_pulse", {31'd0, unit_z_ack}, 32'd1);
    rsp_ack = oh;
    step();
    rsp_ack = 3'b000;
    check("rsp_stb_clr", {29'd0, rsp_stb}, 32'd0);
    check("busy_clr", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z_pass;
    rstn = 1'b0; req_a = '0; req_stb = '0; rsp_ack = '0;
    unit_a_ack = 1'b0; unit_z = '0; unit_z_stb = 1'b0;
    step(); step();
    rstn = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_rsp_stb", {29'd0, rsp_stb}, 32'd0);
    check("rst_req_ack", {29'd0, req_ack}, 32'd0);
    check("rst_timeout", {31'd0, tmo}, 32'd0);

    // Single request, unit result 5 cycles after issue
    unit_a_ack = 1'b1;
    set_ops(32'h00123400, 32'h0, 32'h0);
    req_stb = 3'b001;
    step();
    check("t1_req_ack", {29'd0, req_ack}, 32'd1);
    check("t1_unit_a", unit_a, 32'h00123400);
    check("t1_unit_a_stb", {31'd0, unit_a_stb}, 32'd1);
    req_stb = 3'b000;
    step();
    check("t1_req_ack_pulse", {29'd0, req_ack}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_wait_no_rsp", {29'd0, rsp_stb}, 32'd0);
    end
    unit_z_stb = 1'b1; unit_z = 32'h4991A000;
    step();
    unit_z_stb = 1'b0;
    check("t1_rsp_stb", {29'd0, rsp_stb}, 32'd1);
    check("t1_rsp_z", rsp_z, 32'h4991A000);
    check("t1_z_ack", {31'd0, unit_z_ack}, 32'd1);
    step();
    check("t1_z_ack_pulse", {31'd0, unit_z_ack}, 32'd0);
    rsp_ack = 3'b010;
    step();
    check("t1_wrong_ack_held", {29'd0, rsp_stb}, 32'd1);
    check("t1_rsp_z_stable", rsp_z, 32'h4991A000);
    rsp_ack = 3'b001;
    step();
    rsp_ack = 3'b000;
    check("t1_rsp_clr", {29'd0, rsp_stb}, 32'd0);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);

    // Round-robin after a fresh reset: grants 0,1,2,0
    rstn = 1'b0; step(); rstn = 1'b1;
    set_ops(32'd1, 32'd2, 32'd3);
    req_stb = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack();
      check("rr_grant", {30'd0, grant}, k % 3);
      check("rr_req_ack", {29'd0, req_ack}, 32'd1 << (k % 3));
      check("rr_unit_a", unit_a, (k % 3) + 1);
      z_pass = unit_a;
      finish_txn(3'(1 << (k % 3)), z_pass, (k % 3) + 1);
    end
    req_stb = 3'b000;

    // Back-pressure: unit not ready for 10 cycles, requester 1
    unit_a_ack = 1'b0;
    set_ops(32'h0, 32'hAAAA5555, 32'h0);
    req_stb = 3'b010;
    wait_ack();
    check("bp_grant", {30'd0, grant}, 32'd1);
    req_stb = 3'b000;
    for (int i = 0; i < 10; i++) begin
      check("bp_stb_low", {31'd0, unit_a_stb}, 32'd0);
      check("bp_no_tmo", {31'd0, tmo}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    unit_a_ack = 1'b1;
    #1;
    check("bp_stb_rise", {31'd0, unit_a_stb}, 32'd1);
    check("bp_unit_a", unit_a, 32'hAAAA5555);
    finish_txn(3'b010, 32'h12345678, 32'h12345678);

    // Timeout: requester 2, unit never answers
    set_ops(32'h11110000, 32'h22220000, 32'h33330000);
    req_stb = 3'b100;
    wait_ack();
    check("to_grant", {30'd0, grant}, 32'd2);
    req_stb = 3'b000;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("to_no_tmo_yet", {31'd0, tmo}, 32'd0);
      check("to_no_rsp", {29'd0, rsp_stb}, 32'd0);
    end
    req_stb = 3'b111;
    step();
    check("to_pulse", {31'd0, tmo}, 32'd1);
    check("to_flush_ack", {31'd0, unit_z_ack}, 32'd1);
    check("to_busy_low", {31'd0, busy}, 32'd0);
    check("to_no_rsp_end", {29'd0, rsp_stb}, 32'd0);
    step();
    check("to_pulse_end", {31'd0, tmo}, 32'd0);
    check("to_next_grant", {30'd0, grant}, 32'd0);
    check("to_next_req_ack", {29'd0, req_ack}, 32'd1);
    req_stb = 3'b000;
    finish_txn(3'b001, 32'h3F800000, 32'h3F800000);

    // Z_STB arriving on the same cycle the timeout would fire
    req_stb = 3'b010;
    wait_ack();
    check("zt_grant", {30'd0, grant}, 32'd1);
    req_stb = 3'b000;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("zt_no_tmo_yet", {31'd0, tmo}, 32'd0);
    end
    unit_z_stb = 1'b1; unit_z = 32'hCAFEF00D;
    step();
    unit_z_stb = 1'b0;
    check("zt_no_tmo", {31'd0, tmo}, 32'd0);
    check("zt_rsp_stb", {29'd0, rsp_stb}, 32'd2);
    check("zt_rsp_z", rsp_z, 32'hCAFEF00D);
    rsp_ack = 3'b010;
    step();
    rsp_ack = 3'b000;
    check("zt_busy_clr", {31'd0, busy}, 32'd0);

    // Reset while in ST_RETURN for requester 2
    req_stb = 3'b100;
    wait_ack();
    check("rs_grant", {30'd0, grant}, 32'd2);
    req_stb = 3'b000;
    step();
    unit_z_stb = 1'b1; unit_z = 32'h0BADBEEF;
    step();
    unit_z_stb = 1'b0;
    check("rs_in_return", {29'd0, rsp_stb}, 32'd4);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("rs_rsp_stb", {29'd0, rsp_stb}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_grant0", {30'd0, grant}, 32'd0);
    check("rs_z_ack", {31'd0, unit_z_ack}, 32'd0);
    req_stb = 3'b111;
    step();
    check("rs_next_grant", {30'd0, grant}, 32'd0);
    check("rs_next_req_ack", {29'd0, req_ack}, 32'd1);
    req_stb = 3'b000;
    finish_txn(3'b001, 32'h40000000, 32'h40000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
